uart_echo_initiator: RTL and testbench

- Host-side counterpart of the UART loopback/echo endpoint.
- Accepts a byte over a valid/ready request interface and serialises it on tx as 8N1, LSB first, at a run-time divisor.
- Receives the echoed byte on rx, then reports the result: match, mismatch, framing error or timeout.
- Keeps saturating pass/fail counters; used for link bring-up and board self-test.

---
 rtl/uart_echo_initiator.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_echo_initiator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_initiator.sv
// ---------------------------------------------------------------------------
// uart_echo_initiator
//
// Host-side initiator for a UART echo/loopback endpoint. A byte accepted on
// the request interface is sent on tx as 8N1, LSB first, with a run-time bit
// period of D clocks. The receiver is armed at the start of our stop bit and
// waits for the echo. The outcome (match, mismatch, framing error or
// timeout) is reported as a one-cycle pulse, and saturating pass/fail
// counters are kept for link bring-up and board self-test.
//
// Parameters:
//   TIMEOUT_BITS  echo timeout in bit periods, counted from rx arming
//   SYNC_STAGES   rx synchroniser depth (values below 2 are raised to 2)
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   clks_per_bit  clocks per UART bit (D), latched on acceptance, min 4
//   req_valid     request byte valid
//   req_ready     high only while idle
//   req_data      byte to send
//   tx            serial output, idles high
//   rx            serial input, asynchronous to clk
//   resp_valid    one-cycle result pulse
//   resp_data     received byte (0x00 on timeout), held until next result
//   resp_status   00 match, 01 mismatch, 10 framing error, 11 timeout
//   pass_count    saturating count of matches
//   fail_count    saturating count of all other results
//   busy          inverse of req_ready
// ---------------------------------------------------------------------------
module uart_echo_initiator #(
    parameter int TIMEOUT_BITS = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] clks_per_bit,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_data,
    output logic        tx,
    input  logic        rx,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic [1:0]  resp_status,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count,
    output logic        busy
);

    localparam int SS   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    // Wide enough for the largest 16-bit D times TIMEOUT_BITS.
    localparam int TO_W = 16 + $clog2(TIMEOUT_BITS + 1);

    localparam logic [1:0] ST_MATCH    = 2'b00;
    localparam logic [1:0] ST_MISMATCH = 2'b01;
    localparam logic [1:0] ST_FRAMING  = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_WAIT_RX
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_OFF,
        RX_HUNT,
        RX_START_CHK,
        RX_DATA,
        RX_STOP_CHK,
        RX_REPORT
    } rx_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < 16'd4) ? 16'd4 : d;
    endfunction

    // -----------------------------------------------------------------------
    // rx synchroniser; idles high so reset does not look like a start bit
    // -----------------------------------------------------------------------
    logic [SS-1:0] sync_q;
    logic          rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SS-2:0], rx};
        end
    end

    assign rx_s = sync_q[SS-1];

    // -----------------------------------------------------------------------
    // Transmit side
    // -----------------------------------------------------------------------
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  tx_byte;
    logic [15:0] div;
    logic        tx_q, tx_n;
    logic        accept;
    logic        arm;
    logic        tx_bit_done;

    rx_state_t   rx_state, rx_state_n;

    assign tx_bit_done = (tx_cnt == div - 16'd1);

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        bit_idx_n  = bit_idx;
        accept     = 1'b0;
        arm        = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    tx_state_n = TX_START;
                    tx_cnt_n   = 16'd0;
                    bit_idx_n  = 3'd0;
                end
            end
            TX_START: begin
                if (tx_bit_done) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = 16'd0;
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_bit_done) begin
                    tx_cnt_n = 16'd0;
                    if (bit_idx == 3'd7) begin
                        tx_state_n = TX_STOP;
                        // Receiver is armed for the first cycle of our stop bit.
                        arm        = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_bit_done) begin
                    tx_state_n = TX_WAIT_RX;
                    tx_cnt_n   = 16'd0;
                end else begin
                    tx_cnt_n = tx_cnt + 16'd1;
                end
            end
            TX_WAIT_RX: begin
                if (rx_state == RX_REPORT) begin
                    tx_state_n = TX_IDLE;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
            end
        endcase

        // tx is registered from the next state so the line never glitches.
        case (tx_state_n)
            TX_START: tx_n = 1'b0;
            TX_DATA:  tx_n = tx_byte[bit_idx_n];
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'd0;
            bit_idx  <= 3'd0;
            div      <= 16'd4;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            bit_idx  <= bit_idx_n;
            tx_q     <= tx_n;
            if (accept) begin
                div <= clamp_div(clks_per_bit);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tx_byte <= req_data;
        end
    end

    assign tx        = tx_q;
    assign req_ready = (tx_state == TX_IDLE);
    assign busy      = ~req_ready;

    // -----------------------------------------------------------------------
    // Receive side
    // -----------------------------------------------------------------------
    logic [15:0]     rx_cnt, rx_cnt_n;
    logic [2:0]      rx_bits, rx_bits_n;
    logic [7:0]      rx_byte;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic [TO_W-1:0] to_limit;
    logic            to_hit;
    logic            half_done;
    logic            rx_bit_done;
    logic            shift;
    logic            report_load;
    logic [1:0]      rep_status;
    logic [7:0]      rep_data;

    assign to_limit    = TO_W'(div) * TO_W'(TIMEOUT_BITS);
    assign to_hit      = (to_cnt == to_limit - TO_W'(1));
    assign half_done   = (rx_cnt == (div >> 1) - 16'd1);
    assign rx_bit_done = (rx_cnt == div - 16'd1);

    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bits_n   = rx_bits;
        to_cnt_n    = to_cnt;
        shift       = 1'b0;
        report_load = 1'b0;
        rep_status  = ST_TIMEOUT;
        rep_data    = 8'h00;
        case (rx_state)
            RX_OFF: begin
                if (arm) begin
                    rx_state_n = RX_HUNT;
                    to_cnt_n   = '0;
                end
            end
            RX_HUNT: begin
                if (to_hit) begin
                    rx_state_n  = RX_REPORT;
                    report_load = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + TO_W'(1);
                    if (!rx_s) begin
                        rx_state_n = RX_START_CHK;
                        rx_cnt_n   = 16'd0;
                    end
                end
            end
            RX_START_CHK: begin
                // Timeout keeps running until the start bit is confirmed.
                if (to_hit) begin
                    rx_state_n  = RX_REPORT;
                    report_load = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + TO_W'(1);
                    if (half_done) begin
                        rx_cnt_n = 16'd0;
                        if (rx_s) begin
                            rx_state_n = RX_HUNT;
                        end else begin
                            rx_state_n = RX_DATA;
                            rx_bits_n  = 3'd0;
                        end
                    end else begin
                        rx_cnt_n = rx_cnt + 16'd1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_bit_done) begin
                    shift    = 1'b1;
                    rx_cnt_n = 16'd0;
                    if (rx_bits == 3'd7) begin
                        rx_state_n = RX_STOP_CHK;
                    end else begin
                        rx_bits_n = rx_bits + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            RX_STOP_CHK: begin
                if (rx_bit_done) begin
                    rx_state_n  = RX_REPORT;
                    report_load = 1'b1;
                    rep_data    = rx_byte;
                    if (!rx_s) begin
                        rep_status = ST_FRAMING;
                    end else if (rx_byte == tx_byte) begin
                        rep_status = ST_MATCH;
                    end else begin
                        rep_status = ST_MISMATCH;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 16'd1;
                end
            end
            RX_REPORT: begin
                rx_state_n = RX_OFF;
            end
            default: begin
                rx_state_n = RX_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state    <= RX_OFF;
            rx_cnt      <= 16'd0;
            rx_bits     <= 3'd0;
            to_cnt      <= '0;
            resp_data   <= 8'h00;
            resp_status <= ST_MATCH;
            pass_count  <= 16'd0;
            fail_count  <= 16'd0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bits  <= rx_bits_n;
            to_cnt   <= to_cnt_n;
            if (report_load) begin
                resp_data   <= rep_data;
                resp_status <= rep_status;
            end
            // Result registers are already loaded during the REPORT cycle.
            if (rx_state == RX_REPORT) begin
                if (resp_status == ST_MATCH) begin
                    pass_count <= sat_inc(pass_count);
                end else begin
                    fail_count <= sat_inc(fail_count);
                end
            end
        end
    end

    // LSB arrives first, so shift in from the top.
    always_ff @(posedge clk) begin
        if (shift) begin
            rx_byte <= {rx_s, rx_byte[7:1]};
        end
    end

    assign resp_valid = (rx_state == RX_REPORT);

endmodule

// File: tb/tb_uart_echo_initiator.sv
module tb_uart_echo_initiator;

    localparam int TB = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] clks_per_bit;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_data;
    logic        tx;
    logic        rx;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_status;
    logic [15:0] pass_count;
    logic [15:0] fail_count;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int model_pass = 0;
    int model_fail = 0;

    always #5 clk = ~clk;

    uart_echo_initiator #(.TIMEOUT_BITS(TB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .clks_per_bit(clks_per_bit),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .tx(tx), .rx(rx), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_status(resp_status), .pass_count(pass_count),
        .fail_count(fail_count), .busy(busy)
    );

    typedef struct {
        int         d;
        logic [7:0] data;
        bit         echo_en;
        logic [7:0] echo;
        bit         stop;
        int         off;
        bit         glitch;
        logic [1:0] exp_status;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int deff_of(input int d);
        return (d < 4) ? 4 : d;
    endfunction

    // Result implied by what the far end sent back.
    function automatic void model(input bit echo_en, input logic [7:0] data,
                                  input logic [7:0] echo, input bit stop,
                                  output logic [1:0] st, output logic [7:0] dt);
        if (!echo_en) begin
            st = 2'b11; dt = 8'h00;
        end else if (!stop) begin
            st = 2'b10; dt = echo;
        end else if (echo == data) begin
            st = 2'b00; dt = echo;
        end else begin
            st = 2'b01; dt = echo;
        end
    endfunction

    // Expected tx level k cycles after acceptance (k >= 1).
    function automatic logic tx_level(input int de, input logic [7:0] data, input int k);
        if (k <= de) return 1'b0;
        if (k <= 9 * de) return data[(k - de - 1) / de];
        return 1'b1;
    endfunction

    // Line level the far end drives k cycles after acceptance.
    function automatic logic rx_level(input int de, input bit echo_en, input logic [7:0] echo,
                                      input bit stop, input int off, input bit glitch, input int k);
        int s, e, idx;
        s = 9 * de + 1;
        if (glitch && k >= s + 2 && k < s + 5) return 1'b0;
        if (echo_en) begin
            e = s + off;
            if (k >= e && k < e + 10 * de) begin
                idx = (k - e) / de;
                if (idx == 0) return 1'b0;
                if (idx <= 8) return echo[idx - 1];
                return stop;
            end
        end
        return 1'b1;
    endfunction

    task automatic run_txn(input int d, input logic [7:0] data, input bit echo_en,
                           input logic [7:0] echo, input bit stop, input int off,
                           input bit glitch, input bit keep_valid,
                           input logic [1:0] exp_status, input logic [7:0] exp_data);
        int de, s, budget, tx_err, busy_err, resp_cyc, w;
        logic [1:0] got_st;
        logic [7:0] got_dt;
        de = deff_of(d);
        s = 9 * de + 1;
        budget = 45 * de + 60;
        w = 0;
        while (!req_ready && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        check("ready_before_req", req_ready, 1);
        clks_per_bit = 16'(d);
        req_data = data;
        req_valid = 1'b1;
        @(posedge clk); #1;
        if (keep_valid) req_data = ~data;
        else req_valid = 1'b0;
        tx_err = 0; busy_err = 0; resp_cyc = -1;
        got_st = 2'b00; got_dt = 8'h00;
        for (int k = 1; k <= budget && resp_cyc < 0; k++) begin
            if (k <= 10 * de && tx !== tx_level(de, data, k)) tx_err++;
            if (req_ready !== 1'b0 || busy !== 1'b1) busy_err++;
            if (resp_valid) begin
                resp_cyc = k;
                got_st = resp_status;
                got_dt = resp_data;
            end
            rx = rx_level(de, echo_en, echo, stop, off, glitch, k);
            if (resp_cyc < 0) begin
                @(posedge clk); #1;
            end
        end
        check("resp_seen", resp_cyc > 0, 1);
        check("tx_frame_errors", tx_err, 0);
        check("busy_while_active_errors", busy_err, 0);
        check("resp_status", got_st, exp_status);
        check("resp_data", got_dt, exp_data);
        if (!echo_en) check("timeout_cycle", resp_cyc, s + TB * de);
        if (exp_status == 2'b00) model_pass = (model_pass == 65535) ? 65535 : model_pass + 1;
        else model_fail = (model_fail == 65535) ? 65535 : model_fail + 1;
        @(posedge clk); #1;
        rx = 1'b1;
        check("resp_valid_single", resp_valid, 0);
        check("ready_after_resp", req_ready, 1);
        check("busy_after_resp", busy, 0);
        check("resp_status_held", resp_status, exp_status);
        check("resp_data_held", resp_data, exp_data);
        check("pass_count", pass_count, model_pass);
        check("fail_count", fail_count, model_fail);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] st;
        logic [7:0] dt;
        int pulses;
        int tx_low;

        vecs[0] = '{8,  8'hA5, 1'b1, 8'hA5, 1'b1, 4,  1'b0, 2'b00, 8'hA5};
        vecs[1] = '{8,  8'hA5, 1'b1, 8'h5A, 1'b1, 4,  1'b0, 2'b01, 8'h5A};
        vecs[2] = '{8,  8'hA5, 1'b0, 8'h00, 1'b1, 0,  1'b0, 2'b11, 8'h00};
        vecs[3] = '{16, 8'h3C, 1'b1, 8'h96, 1'b0, 20, 1'b1, 2'b10, 8'h96};
        vecs[4] = '{2,  8'h0F, 1'b1, 8'h0F, 1'b1, 3,  1'b0, 2'b00, 8'h0F};

        rst = 1'b1;
        rx = 1'b1;
        req_valid = 1'b0;
        req_data = 8'h00;
        clks_per_bit = 16'd8;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", tx, 1);
        check("reset_req_ready", req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_data", resp_data, 8'h00);
        check("reset_resp_status", resp_status, 2'b00);
        check("reset_pass_count", pass_count, 0);
        check("reset_fail_count", fail_count, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].d, vecs[i].data, vecs[i].echo_en, vecs[i].echo, vecs[i].stop,
                    vecs[i].off, vecs[i].glitch, 1'b0, vecs[i].exp_status, vecs[i].exp_data);
        end

        for (int i = 0; i < 12; i++) begin
            int d, kind, off;
            logic [7:0] data, echo;
            bit en, stop;
            d = $urandom_range(0, 10);
            data = 8'($urandom);
            kind = $urandom_range(0, 3);
            en = (kind != 3);
            stop = (kind != 2);
            echo = (kind == 1) ? (data ^ 8'($urandom_range(1, 255))) : data;
            if (kind == 2) echo = 8'($urandom);
            off = $urandom_range(0, 3 * deff_of(d));
            model(en, data, echo, stop, st, dt);
            run_txn(d, data, en, echo, stop, off, 1'b0, 1'b0, st, dt);
        end

        // req_valid held high: second byte accepted only after the response.
        run_txn(8, 8'h3C, 1'b1, 8'h3C, 1'b1, 6, 1'b0, 1'b1, 2'b00, 8'h3C);
        @(posedge clk); #1;
        check("second_accept_tx_low", tx, 0);
        check("second_accept_busy", busy, 1);
        repeat (11) @(posedge clk);
        #1;
        req_valid = 1'b0;

        // Reset in the middle of the data bits.
        rst = 1'b1;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_pass_count", pass_count, 0);
        check("midrst_fail_count", fail_count, 0);
        check("midrst_resp_data", resp_data, 8'h00);
        model_pass = 0;
        model_fail = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        tx_low = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (resp_valid) pulses++;
            if (!tx) tx_low++;
        end
        check("post_reset_no_resp", pulses, 0);
        check("post_reset_tx_idle", tx_low, 0);

        // Normal operation resumes after the abort.
        run_txn(8, 8'hC3, 1'b1, 8'hC3, 1'b1, 2, 1'b0, 1'b0, 2'b00, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
